// File: rtl/rx_buffer_write_ctrl.sv
// RX slot buffer write sequencer: packs MAC bytes into words, writes them into the current slot, then reports size and commits.
// Optional macro RX_BUF_CRC_STRIP_EN: reported frame size excludes the 4-byte FCS (FCS bytes are still written).
module rx_buffer_write_ctrl #(
    parameter int data_width_p = 64,
    parameter int max_bytes_p  = 2048,
    parameter int min_bytes_p  = 14
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    rx_v_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_last_i,
    input  logic                    rx_error_i,
    input  logic                    write_slot_ready_and_i,
    output logic                    write_slot_v_o,
    output logic                    write_size_v_o,
    output logic [15:0]             write_size_o,
    output logic                    write_v_o,
    output logic [10:0]             write_addr_o,
    output logic [data_width_p-1:0] write_data_o,
    output logic [15:0]             drop_count_o,
    output logic                    busy_o
);
    localparam int num_lanes = data_width_p / 8;
    localparam int lane_w    = $clog2(num_lanes);
    localparam logic [11:0] max_cnt = 12'(max_bytes_p);
    localparam logic [11:0] min_cnt = 12'(min_bytes_p);

    typedef enum logic [1:0] {IDLE, RECV, DROP, COMMIT} state_t;

    state_t                  state_reg, state_next;
    logic [11:0]             byte_cnt_reg, byte_cnt_next;
    logic [data_width_p-1:0] pack_reg, pack_next;
    logic                    write_v_reg, write_v_next;
    logic [10:0]             write_addr_reg, write_addr_next;
    logic [data_width_p-1:0] write_data_reg, write_data_next;
    logic                    write_size_v_reg, write_size_v_next;
    logic [15:0]             write_size_reg, write_size_next;
    logic                    write_slot_v_reg, write_slot_v_next;
    logic [15:0]             drop_count_reg, drop_count_next;
    logic                    drop_inc;

    logic [lane_w-1:0]       lane;
    logic [data_width_p-1:0] pack_base;
    logic [data_width_p-1:0] pack_merged;
    logic [11:0]             cnt_inc;
    logic                    abort;

    // Only the RECV state has a partially filled word; a new frame always starts from an empty word in lane 0.
    assign lane      = (state_reg == RECV) ? byte_cnt_reg[lane_w-1:0] : '0;
    assign pack_base = (state_reg == RECV) ? pack_reg : '0;
    assign cnt_inc   = byte_cnt_reg + 12'd1;
    assign abort     = rx_error_i || (byte_cnt_reg == max_cnt);

    genvar gi;
    generate
        for (gi = 0; gi < num_lanes; gi++) begin : g_lane
            assign pack_merged[gi*8 +: 8] = (lane == lane_w'(gi)) ? rx_data_i : pack_base[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        byte_cnt_next     = byte_cnt_reg;
        pack_next         = pack_reg;
        write_v_next      = 1'b0;
        write_addr_next   = write_addr_reg;
        write_data_next   = write_data_reg;
        write_size_v_next = 1'b0;
        write_size_next   = write_size_reg;
        write_slot_v_next = (state_reg == COMMIT);
        drop_inc          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_v_i) begin
                    if (rx_last_i) begin
                        drop_inc = 1'b1;
                    end else if (!write_slot_ready_and_i || rx_error_i) begin
                        drop_inc   = 1'b1;
                        state_next = DROP;
                    end else begin
                        state_next    = RECV;
                        byte_cnt_next = 12'd1;
                        pack_next     = pack_merged;
                    end
                end
            end
            RECV: begin
                if (rx_v_i) begin
                    if (abort || (rx_last_i && (cnt_inc < min_cnt))) begin
                        drop_inc      = 1'b1;
                        pack_next     = '0;
                        byte_cnt_next = '0;
                        state_next    = rx_last_i ? IDLE : DROP;
                    end else begin
                        byte_cnt_next = cnt_inc;
                        if (rx_last_i || (lane == lane_w'(num_lanes - 1))) begin
                            write_v_next    = 1'b1;
                            write_addr_next = byte_cnt_reg[10:0] & ~11'(num_lanes - 1);
                            write_data_next = pack_merged;
                            pack_next       = '0;
                        end else begin
                            pack_next = pack_merged;
                        end
                        if (rx_last_i) begin
                            write_size_v_next = 1'b1;
`ifdef RX_BUF_CRC_STRIP_EN
                            write_size_next   = {4'd0, cnt_inc} - 16'd4;
`else
                            write_size_next   = {4'd0, cnt_inc};
`endif
                            byte_cnt_next     = '0;
                            state_next        = COMMIT;
                        end
                    end
                end
            end
            DROP: begin
                if (rx_v_i && rx_last_i) begin
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                // A byte here breaks the MAC framing contract; its frame is discarded.
                state_next = IDLE;
                if (rx_v_i) begin
                    drop_inc   = 1'b1;
                    state_next = rx_last_i ? IDLE : DROP;
                end
            end
            default: state_next = IDLE;
        endcase

        drop_count_next = (drop_inc && (drop_count_reg != 16'hFFFF)) ? drop_count_reg + 16'd1
                                                                     : drop_count_reg;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg        <= IDLE;
            byte_cnt_reg     <= '0;
            pack_reg         <= '0;
            write_v_reg      <= 1'b0;
            write_addr_reg   <= '0;
            write_data_reg   <= '0;
            write_size_v_reg <= 1'b0;
            write_size_reg   <= '0;
            write_slot_v_reg <= 1'b0;
            drop_count_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            byte_cnt_reg     <= byte_cnt_next;
            pack_reg         <= pack_next;
            write_v_reg      <= write_v_next;
            write_addr_reg   <= write_addr_next;
            write_data_reg   <= write_data_next;
            write_size_v_reg <= write_size_v_next;
            write_size_reg   <= write_size_next;
            write_slot_v_reg <= write_slot_v_next;
            drop_count_reg   <= drop_count_next;
        end
    end

    assign write_slot_v_o = write_slot_v_reg;
    assign write_size_v_o = write_size_v_reg;
    assign write_size_o   = write_size_reg;
    assign write_v_o      = write_v_reg;
    assign write_addr_o   = write_addr_reg;
    assign write_data_o   = write_data_reg;
    assign drop_count_o   = drop_count_reg;
    assign busy_o         = (state_reg != IDLE);

endmodule

// File: tb/tb_rx_buffer_write_ctrl.sv
// Self-checking bench for rx_buffer_write_ctrl: directed frame table, corner sequences and random frames vs a frame-level model.
module tb_rx_buffer_write_ctrl;
    localparam int DW   = 64;
    localparam int NL   = DW / 8;
    localparam int MAXB = 2048;
    localparam int MINB = 14;
`ifdef RX_BUF_CRC_STRIP_EN
    localparam int SIZE_ADJ = 4;
`else
    localparam int SIZE_ADJ = 0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          rx_v_i = 1'b0;
    logic [7:0]    rx_data_i = '0;
    logic          rx_last_i = 1'b0;
    logic          rx_error_i = 1'b0;
    logic          write_slot_ready_and_i = 1'b1;
    logic          write_slot_v_o;
    logic          write_size_v_o;
    logic [15:0]   write_size_o;
    logic          write_v_o;
    logic [10:0]   write_addr_o;
    logic [DW-1:0] write_data_o;
    logic [15:0]   drop_count_o;
    logic          busy_o;

    rx_buffer_write_ctrl #(.data_width_p(DW), .max_bytes_p(MAXB), .min_bytes_p(MINB)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .rx_v_i(rx_v_i), .rx_data_i(rx_data_i),
        .rx_last_i(rx_last_i), .rx_error_i(rx_error_i), .write_slot_ready_and_i(write_slot_ready_and_i),
        .write_slot_v_o(write_slot_v_o), .write_size_v_o(write_size_v_o), .write_size_o(write_size_o),
        .write_v_o(write_v_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
        .drop_count_o(drop_count_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
        bit            size_v;
        int            size;
        int            cyc;
    } wr_t;

    typedef struct {
        int len;
        bit rdy;
        int err_pos;
        bit gaps;
        int exp_writes;
        bit exp_commit;
        int exp_size;
    } vec_t;

    wr_t  act_q[$];
    wr_t  exp_q[$];
    int   act_commit_q[$];
    int   exp_commit_q[$];
    wr_t  mon_w;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   model_drop = 0;
    logic [7:0] fb [0:2099];
    int   stamp [0:2099];
    vec_t vecs [14];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Output monitor: collects every write and commit with the cycle it appeared in.
    initial forever begin
        @(negedge clk_i);
        if (reset_n_i) begin
            if (write_v_o) begin
                mon_w.addr   = int'(write_addr_o);
                mon_w.data   = write_data_o;
                mon_w.size_v = write_size_v_o;
                mon_w.size   = int'(write_size_o);
                mon_w.cyc    = cyc;
                act_q.push_back(mon_w);
                checks++;
                if ((int'(write_addr_o) % NL) != 0 || int'(write_addr_o) > MAXB - NL) begin
                    errors++;
                    $display("FAIL addr_range: got %0h required aligned to %0d and <= %0h", write_addr_o, NL, MAXB - NL);
                end
            end
            if (write_size_v_o) begin
                checks++;
                if (!write_v_o) begin
                    errors++;
                    $display("FAIL size_with_write: got write_v=%0d required 1", write_v_o);
                end
            end
            if (write_slot_v_o) act_commit_q.push_back(cyc);
        end
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL timeout: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            rx_v_i = 1'b0; rx_last_i = 1'b0; rx_error_i = 1'b0;
        end
    endtask

    task automatic drive_frame(input int n, input bit rdy, input int err_pos, input bit gaps);
        int g;
        for (int i = 1; i <= n; i++) begin
            g = (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            repeat (g) begin
                @(negedge clk_i);
                rx_v_i = 1'b0; rx_last_i = 1'b0; rx_error_i = 1'b0;
            end
            @(negedge clk_i);
            rx_v_i = 1'b1;
            rx_data_i = fb[i-1];
            rx_last_i = (i == n);
            rx_error_i = (i == err_pos);
            write_slot_ready_and_i = rdy;
            stamp[i] = cyc;
        end
    endtask

    // Frame-level reference: which bytes get stored, how they pack into words, and when results appear.
    task automatic build_expected(input int n, input bit rdy, input int err_pos);
        int  abort_at, stored, nwords, last_idx;
        bit  accept;
        wr_t w;
        exp_q.delete();
        exp_commit_q.delete();
        abort_at = 0; accept = 1'b0; stored = 0;
        if (rdy && n > 1) begin
            if (err_pos > 0) abort_at = err_pos;
            if (n > MAXB && (abort_at == 0 || MAXB + 1 < abort_at)) abort_at = MAXB + 1;
            if (abort_at == 0 && n < MINB) abort_at = n;
            accept = (abort_at == 0);
            stored = accept ? n : abort_at - 1;
        end
        nwords = accept ? (stored + NL - 1) / NL : stored / NL;
        for (int j = 0; j < nwords; j++) begin
            w.addr = j * NL;
            w.data = '0;
            for (int l = 0; l < NL; l++)
                if (j * NL + l < stored) w.data[l*8 +: 8] = fb[j*NL + l];
            last_idx = ((j + 1) * NL < stored) ? (j + 1) * NL : stored;
            w.cyc = stamp[last_idx] + 1;
            w.size_v = accept && (j == nwords - 1);
            w.size = w.size_v ? n - SIZE_ADJ : 0;
            exp_q.push_back(w);
        end
        if (accept) exp_commit_q.push_back(stamp[n] + 2);
        else if (model_drop < 65535) model_drop++;
    endtask

    task automatic compare_frame(input string name);
        checks++;
        if (act_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, act_q.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < act_q.size(); j++) begin
            checks++;
            if (act_q[j].addr != exp_q[j].addr || act_q[j].data != exp_q[j].data ||
                act_q[j].size_v != exp_q[j].size_v || act_q[j].cyc != exp_q[j].cyc ||
                (exp_q[j].size_v && act_q[j].size != exp_q[j].size)) begin
                errors++;
                $display("FAIL %s write[%0d]: got addr=%0h data=%h sv=%0d size=%0d cyc=%0d required addr=%0h data=%h sv=%0d size=%0d cyc=%0d",
                         name, j, act_q[j].addr, act_q[j].data, act_q[j].size_v, act_q[j].size, act_q[j].cyc,
                         exp_q[j].addr, exp_q[j].data, exp_q[j].size_v, exp_q[j].size, exp_q[j].cyc);
            end
        end
        checks++;
        if (act_commit_q.size() != exp_commit_q.size() ||
            (exp_commit_q.size() == 1 && act_commit_q[0] != exp_commit_q[0])) begin
            errors++;
            $display("FAIL %s commit: got %0d pulses (first cyc %0d) required %0d (cyc %0d)", name,
                     act_commit_q.size(), (act_commit_q.size() > 0) ? act_commit_q[0] : -1,
                     exp_commit_q.size(), (exp_commit_q.size() > 0) ? exp_commit_q[0] : -1);
        end
        checks++;
        if (drop_count_o != 16'(model_drop)) begin
            errors++;
            $display("FAIL %s drop_count: got %0d required %0d", name, drop_count_o, model_drop);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_idle: got %0d required 0", name, busy_o);
        end
        $display("frame %s: writes=%0d commits=%0d drop_count=%0d", name, act_q.size(), act_commit_q.size(), drop_count_o);
        act_q.delete();
        act_commit_q.delete();
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 2100; i++) fb[i] = 8'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2100; i++) fb[i] = 8'($urandom);
    endtask

    initial begin
        int n, err;
        bit rdy, gaps;

        vecs[0]  = '{64,   1'b1, 0,  1'b0, 8,   1'b1, 64};
        vecs[1]  = '{61,   1'b1, 0,  1'b0, 8,   1'b1, 61};
        vecs[2]  = '{100,  1'b0, 0,  1'b0, 0,   1'b0, 0};
        vecs[3]  = '{64,   1'b1, 0,  1'b0, 8,   1'b1, 64};
        vecs[4]  = '{60,   1'b1, 30, 1'b0, 3,   1'b0, 0};
        vecs[5]  = '{64,   1'b1, 0,  1'b0, 8,   1'b1, 64};
        vecs[6]  = '{2049, 1'b1, 0,  1'b0, 256, 1'b0, 0};
        vecs[7]  = '{10,   1'b1, 0,  1'b0, 1,   1'b0, 0};
        vecs[8]  = '{14,   1'b1, 0,  1'b0, 2,   1'b1, 14};
        vecs[9]  = '{13,   1'b1, 0,  1'b0, 1,   1'b0, 0};
        vecs[10] = '{2048, 1'b1, 0,  1'b0, 256, 1'b1, 2048};
        vecs[11] = '{1,    1'b1, 0,  1'b0, 0,   1'b0, 0};
        vecs[12] = '{64,   1'b1, 0,  1'b1, 8,   1'b1, 64};
        vecs[13] = '{20,   1'b1, 20, 1'b0, 2,   1'b0, 0};

        // Reset state.
        #1;
        checks++;
        if ({write_slot_v_o, write_size_v_o, write_size_o, write_v_o, write_addr_o, write_data_o, drop_count_o, busy_o} != '0) begin
            errors++;
            $display("FAIL reset_state: got nonzero outputs drop=%0d busy=%0d wv=%0d", drop_count_o, busy_o, write_v_o);
        end
        idle(3);
        reset_n_i = 1'b1;
        idle(2);

        for (int v = 0; v < 14; v++) begin
            fill_pattern();
            drive_frame(vecs[v].len, vecs[v].rdy, vecs[v].err_pos, vecs[v].gaps);
            build_expected(vecs[v].len, vecs[v].rdy, vecs[v].err_pos);
            idle(4);
            checks++;
            if (act_q.size() != vecs[v].exp_writes || act_commit_q.size() != int'(vecs[v].exp_commit)) begin
                errors++;
                $display("FAIL vec%0d summary: got writes=%0d commits=%0d required writes=%0d commits=%0d",
                         v, act_q.size(), act_commit_q.size(), vecs[v].exp_writes, vecs[v].exp_commit);
            end
            if (vecs[v].exp_commit && act_q.size() > 0) begin
                checks++;
                if (!act_q[act_q.size()-1].size_v || act_q[act_q.size()-1].size != vecs[v].exp_size - SIZE_ADJ) begin
                    errors++;
                    $display("FAIL vec%0d size: got sv=%0d size=%0d required size=%0d", v,
                             act_q[act_q.size()-1].size_v, act_q[act_q.size()-1].size, vecs[v].exp_size - SIZE_ADJ);
                end
            end
            if (v == 0 && act_q.size() > 0) begin
                checks++;
                if (act_q[0].data != 64'h0706050403020100 || act_q[0].addr != 0) begin
                    errors++;
                    $display("FAIL first_word: got addr=%0h data=%h required 0 / 0706050403020100", act_q[0].addr, act_q[0].data);
                end
            end
            if (v == 1 && act_q.size() == 8) begin
                checks++;
                if (act_q[7].addr != 'h38 || act_q[7].data[63:40] != '0) begin
                    errors++;
                    $display("FAIL partial_word: got addr=%0h data=%h required addr 38 with lanes 5..7 zero", act_q[7].addr, act_q[7].data);
                end
            end
            compare_frame($sformatf("vec%0d_len%0d", v, vecs[v].len));
        end

        // A byte arriving during the commit cycle starts a frame that must be discarded.
        fill_pattern();
        drive_frame(14, 1'b1, 0, 1'b0);
        build_expected(14, 1'b1, 0);
        drive_frame(20, 1'b1, 0, 1'b0);
        if (model_drop < 65535) model_drop++;
        idle(4);
        compare_frame("commit_overlap");

        // Reset mid-frame: outputs clear immediately and the partial frame never commits.
        fill_pattern();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            rx_v_i = 1'b1; rx_data_i = fb[i-1]; rx_last_i = 1'b0; rx_error_i = 1'b0;
            write_slot_ready_and_i = 1'b1;
        end
        @(negedge clk_i);
        rx_v_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_midframe: got %0d required 1", busy_o);
        end
        reset_n_i = 1'b0;
        #1;
        checks++;
        if ({write_slot_v_o, write_size_v_o, write_size_o, write_v_o, write_addr_o, write_data_o, drop_count_o, busy_o} != '0) begin
            errors++;
            $display("FAIL async_reset: got drop=%0d busy=%0d addr=%0h data=%h required all 0", drop_count_o, busy_o, write_addr_o, write_data_o);
        end
        idle(2);
        reset_n_i = 1'b1;
        checks++;
        if (act_commit_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_commit: got %0d commits required 0", act_commit_q.size());
        end
        act_q.delete();
        act_commit_q.delete();
        model_drop = 0;
        idle(2);
        drive_frame(64, 1'b1, 0, 1'b0);
        build_expected(64, 1'b1, 0);
        idle(4);
        compare_frame("after_reset_64");

        // Drop counter saturation using back-to-back single-byte runts.
        for (int k = 0; k < 65534; k++) begin
            @(negedge clk_i);
            rx_v_i = 1'b1; rx_last_i = 1'b1; rx_error_i = 1'b0; rx_data_i = 8'(k);
        end
        idle(1);
        checks++;
        if (drop_count_o != 16'hFFFE) begin
            errors++;
            $display("FAIL drop_65534: got %h required fffe", drop_count_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            rx_v_i = 1'b1; rx_last_i = 1'b1; rx_error_i = 1'b0;
            if (k == 1) begin
                idle(1);
                checks++;
                if (drop_count_o != 16'hFFFF) begin
                    errors++;
                    $display("FAIL drop_sat: got %h required ffff", drop_count_o);
                end
            end
        end
        idle(2);
        checks++;
        if (drop_count_o != 16'hFFFF || act_q.size() != 0) begin
            errors++;
            $display("FAIL drop_hold: got %h writes=%0d required ffff writes=0", drop_count_o, act_q.size());
        end
        $display("saturation: drop_count=%h", drop_count_o);

        // Randomized frames against the model, starting from a fresh counter.
        reset_n_i = 1'b0;
        idle(2);
        reset_n_i = 1'b1;
        model_drop = 0;
        act_q.delete();
        act_commit_q.delete();
        idle(2);
        for (int r = 0; r < 25; r++) begin
            n    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 16)) : int'($urandom_range(14, 200));
            rdy  = ($urandom_range(0, 5) != 0);
            err  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, n)) : 0;
            gaps = 1'($urandom_range(0, 1));
            fill_random();
            drive_frame(n, rdy, err, gaps);
            build_expected(n, rdy, err);
            idle(4);
            compare_frame($sformatf("rand%0d_len%0d_rdy%0d_err%0d", r, n, rdy, err));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_buffer_write_ctrl.md
Name: rx_buffer_write_ctrl

Overview:
- MAC-side sequencer for the RX slot buffer.
- Accepts the byte stream from the 1G MAC receive path and packs it into data_width_p-wide words.
- Issues aligned word writes into the buffer's current write slot, then records the frame byte count and commits the slot.
- Frames are dropped without committing when no slot is free, when the MAC flags an error, or when the frame is too short or too long.

Parameters:
- data_width_p, 64, buffer write word width; legal values 64 or 32.
- max_bytes_p, 2048, largest frame accepted; must not exceed the slot capacity of 2048 bytes.
- min_bytes_p, 14, smallest frame accepted; shorter frames are runts and are dropped.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- rx_v_i  in  1  byte valid from MAC; no backpressure toward the MAC.
- rx_data_i  in  8  frame byte.
- rx_last_i  in  1  qualifies the final byte of the frame.
- rx_error_i  in  1  frame bad; sampled on any valid byte.
- write_slot_ready_and_i  in  1  buffer has a free slot.
- write_slot_v_o  out  1  commit pulse for the current slot.
- write_size_v_o  out  1  size write strobe.
- write_size_o  out  16  frame byte count.
- write_v_o  out  1  word write strobe.
- write_addr_o  out  11  byte address, aligned to data_width_p/8.
- write_data_o  out  data_width_p  packed word; byte 0 sits in bits [7:0].
- drop_count_o  out  16  count of dropped frames, saturating.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs are 0, FSM is IDLE, counters and the pack register are cleared.
- FSM states: IDLE, RECV, DROP, COMMIT.
- IDLE, first valid byte:
  - If write_slot_ready_and_i=1: go to RECV, byte_cnt=1, the byte lands in lane 0.
  - If write_slot_ready_and_i=0: go to DROP.
  - If that byte also has rx_last_i=1: treat it as a runt and drop it; stay in IDLE; drop_count increments.
- RECV, each valid byte:
  - Byte goes into lane byte_cnt mod W, where W=data_width_p/8; byte_cnt increments.
  - When a lane W-1 byte arrives, the next cycle shows write_v_o=1, write_addr_o = word_idx*W, and write_data_o = the full word. Write latency is 1 cycle from the completing byte.
- Error / overflow: rx_error_i=1 on any byte, or byte_cnt reaching max_bytes_p+1, sends the FSM to DROP. No size write and no commit happen; the slot stays uncommitted and gets overwritten by the next frame.
- RECV, byte with rx_last_i=1:
  - If byte_cnt < min_bytes_p, or an error is present: drop, going to IDLE (or staying in DROP).
  - Otherwise, next cycle: write_v_o=1 carrying any partial word, with unused upper lanes at 0 (a full last word is the normal write). In the same cycle write_size_v_o=1 and write_size_o=byte_cnt. The FSM then enters COMMIT.
- COMMIT (one cycle): write_slot_v_o=1, then go to IDLE.
  - write_slot_ready_and_i is guaranteed 1 here, because this block is the only producer and the slot was held from frame start.
  - A valid byte arriving in COMMIT is a protocol violation: it starts a new frame that is dropped (go to DROP, drop_count+1).
- DROP: consume bytes with no writes; return to IDLE on the byte with rx_last_i=1. drop_count increments once per dropped frame and holds at 16'hFFFF.
- Gaps in rx_v_i mid-frame are legal: state and pack register hold.
- Reset asserted mid-frame: the frame is abandoned; no commit and no size write are issued.
- write_addr_o is always aligned to W and never exceeds max_bytes_p-W.

Optional Feature:
- Macro: RX_BUF_CRC_STRIP_EN.
- Defined: write_size_o = byte_cnt-4, so the 4-byte FCS is excluded from the reported size (FCS bytes are still written to memory). min_bytes_p is checked against the pre-strip byte_cnt.
- Undefined: write_size_o = byte_cnt, FCS included.

Test Plan:
- 64-byte frame (bytes 0x00..0x3F), slot free -> 8 writes at addrs 0x000..0x038 (first word 0x0706050403020100), size=64 at the final write, commit pulse one cycle later.
- 61-byte frame -> 8 writes; last word at 0x038 has lanes 5..7 zero; size=61. With RX_BUF_CRC_STRIP_EN the size is 57.
- write_slot_ready_and_i=0 at first byte of a 100-byte frame -> no write_v_o/size/commit; drop_count 0->1; the next frame with a slot free is accepted normally.
- rx_error_i on byte 30 of a 60-byte frame -> writes for words 0..2 only, no size/commit, drop_count+1; the following 64-byte frame reuses the slot starting at addr 0.
- 2049-byte frame -> DROP at byte 2049, no commit; 10-byte runt -> no commit, drop_count+1.
- Reset_n_i pulsed low at byte 20 -> all outputs 0 immediately; a following 64-byte frame commits correctly; 65536 drops -> drop_count saturates at 0xFFFF.
